// File: rtl/complex_mul_pkg.sv
// rtl/complex_mul_pkg.sv - shared defaults and tag type for complex_mul_arb
package complex_mul_pkg;

  localparam int DATA_LEN_DEF = 8;
  localparam int MUL_LAT_DEF  = 6;

  // Wide enough for the largest supported requester count (8)
  localparam int ID_W = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/complex_mul_arb_rr_arbiter.sv
// rtl/complex_mul_arb_rr_arbiter.sv - round-robin one-hot grant from a request vector and pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  // Walk priority positions ptr, ptr+1, ... (mod NUM_REQ) and grant the first active request
  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (((int'(ptr) + k) % NUM_REQ) == i)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/complex_mul_arb.sv
// rtl/complex_mul_arb.sv - round-robin front end sharing one pipelined complex multiplier
module complex_mul_arb
  import complex_mul_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int MUL_LAT  = MUL_LAT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_REQ-1:0]          req_vld,
  output logic [NUM_REQ-1:0]          req_rdy,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_a1,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_b1,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_a2,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_b2,
  output logic                        mul_in_vld,
  output logic [DATA_LEN-1:0]         mul_a1,
  output logic [DATA_LEN-1:0]         mul_b1,
  output logic [DATA_LEN-1:0]         mul_a2,
  output logic [DATA_LEN-1:0]         mul_b2,
  output logic                        mul_rst,
  input  logic                        mul_out_vld,
  input  logic [2*DATA_LEN-1:0]       mul_a_out,
  input  logic [2*DATA_LEN-1:0]       mul_b_out,
  output logic [NUM_REQ-1:0]          res_vld,
  output logic [2*DATA_LEN-1:0]       res_a,
  output logic [2*DATA_LEN-1:0]       res_b,
  output logic                        idle,
  output logic                        err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MUL_LAT + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MUL_LAT + 1);

  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    ptr_next;
  logic [NUM_REQ-1:0]  gnt;
  logic                xfer;
  logic [ID_W-1:0]     gnt_id;
  logic [DATA_LEN-1:0] sel_a1, sel_b1, sel_a2, sel_b2;
  tag_t                tag_q [MUL_LAT+1];
  tag_t                tag_out;
  logic [CNT_W-1:0]    inflight;
  logic [CNT_W-1:0]    mask_cnt;
  logic                masked;
  logic                res_hit;
  logic                tag_err;
  logic [NUM_REQ-1:0]  res_sel;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_rr_arbiter (
    .req(req_vld),
    .ptr(ptr),
    .gnt(gnt)
  );

  assign req_rdy = (en && rst_n) ? gnt : '0;
  assign xfer    = |(req_vld & req_rdy);
  assign tag_out = tag_q[MUL_LAT];
  assign masked  = (mask_cnt != '0);
  assign res_hit = !masked && mul_out_vld && tag_out.valid;
  assign tag_err = !masked && (mul_out_vld != tag_out.valid);
  assign idle    = (inflight == '0) && !(|req_rdy);

  // Encode the accepted requester, its successor pointer and its operand slices
  always_comb begin
    gnt_id   = '0;
    ptr_next = ptr;
    sel_a1   = '0;
    sel_b1   = '0;
    sel_a2   = '0;
    sel_b2   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_rdy[i]) begin
        gnt_id   = ID_W'(i);
        ptr_next = PTR_W'((i + 1) % NUM_REQ);
        sel_a1   = req_a1[i*DATA_LEN +: DATA_LEN];
        sel_b1   = req_b1[i*DATA_LEN +: DATA_LEN];
        sel_a2   = req_a2[i*DATA_LEN +: DATA_LEN];
        sel_b2   = req_b2[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

  // Decode the tag-line owner into a one-hot result strobe
  always_comb begin
    res_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      res_sel[i] = (tag_out.id == ID_W'(i));
    end
  end

  // Pointer moves just past the requester that was served
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= ptr_next;
    end
  end

  // Operand register feeding the shared multiplier; operands hold between issues
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_in_vld <= 1'b0;
      mul_a1     <= '0;
      mul_b1     <= '0;
      mul_a2     <= '0;
      mul_b2     <= '0;
    end else begin
      mul_in_vld <= xfer;
      if (xfer) begin
        mul_a1 <= sel_a1;
        mul_b1 <= sel_b1;
        mul_a2 <= sel_a2;
        mul_b2 <= sel_b2;
      end
    end
  end

  // Multiplier reset is rst_n inverted through one register
  always_ff @(posedge clk) begin
    mul_rst <= !rst_n;
  end

  // Tag line shadows the multiplier pipeline so each result finds its owner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= MUL_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0].valid <= xfer;
      tag_q[0].id    <= gnt_id;
      for (int k = 1; k <= MUL_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // Stale multiplier output from before reset is ignored for MUL_LAT+1 cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_cnt <= CNT_MAX;
    end else if (masked) begin
      mask_cnt <= mask_cnt - CNT_W'(1);
    end
  end

  // In-flight count: issue adds one, retirement off the tag line removes one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({xfer, tag_out.valid})
        2'b10: if (inflight != CNT_MAX) inflight <= inflight + CNT_W'(1);
        2'b01: if (inflight != '0)      inflight <= inflight - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Result register and sticky strobe/tag disagreement flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_vld <= '0;
      res_a   <= '0;
      res_b   <= '0;
      err     <= 1'b0;
    end else begin
      res_vld <= res_hit ? res_sel : '0;
      if (res_hit) begin
        res_a <= mul_a_out;
        res_b <= mul_b_out;
      end
      if (tag_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/complex_mul_arb.md
COMPLEX_MUL_ARB -- requirements
Module: complex_mul_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_LEN, default 8, operand width in bits.
REQ-003 SHALL have parameter MUL_LAT, default 6, cycles from mul_in_vld to mul_out_vld of the shared multiplier.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 SHALL have port: clk  in  1  rising-edge clock for all state.
REQ-006 SHALL have port: rst_n  in  1  synchronous active-low reset.
REQ-007 SHALL have port: en  in  1  when low, no new grants; in-flight operations still complete.
REQ-008 SHALL have port: req_vld  in  NUM_REQ  per-requester operand valid.
REQ-009 SHALL have port: req_rdy  out  NUM_REQ  per-requester accept, one-hot or zero.
REQ-010 SHALL have port: req_a1, req_b1, req_a2, req_b2  in  NUM_REQ*DATA_LEN each  packed signed operands (re1, im1, re2, im2); slice i belongs to requester i.
REQ-011 SHALL have port: mul_in_vld  out  1  operand strobe to the multiplier.
REQ-012 SHALL have port: mul_a1, mul_b1, mul_a2, mul_b2  out  DATA_LEN each  registered operands to the multiplier.
REQ-013 SHALL have port: mul_rst  out  1  active-high multiplier reset, registered inverse of rst_n.
REQ-014 SHALL have port: mul_out_vld  in  1; mul_a_out, mul_b_out  in  2*DATA_LEN each  multiplier result.
REQ-015 SHALL have port: res_vld  out  NUM_REQ  one-hot result strobe to owning requester.
REQ-016 SHALL have port: res_a, res_b  out  2*DATA_LEN each  registered result (real, imag), shared by all requesters.
REQ-017 SHALL have port: idle  out  1  high when in-flight count is 0 and no grant is pending.
REQ-018 SHALL have port: err  out  1  sticky tag/strobe mismatch flag.

Function
REQ-019 Arbitration SHALL be round-robin: grant goes to the first requester with req_vld high at or after pointer ptr, searching upward modulo NUM_REQ.
REQ-020 At most one grant per cycle; req_rdy[i] SHALL be combinational, high only for the granted i, and only while en is high.
REQ-021 A transfer occurs when req_vld[i] and req_rdy[i] are both high; ptr SHALL become (i+1) mod NUM_REQ on the next cycle, otherwise it holds.
REQ-022 On a transfer, mul_in_vld SHALL be high on the next cycle with mul_a1..mul_b2 equal to slice i of the operands; otherwise mul_in_vld is low and operands hold.
REQ-023 A tag line of MUL_LAT+1 stages SHALL carry {valid, id} alongside each issued operation.
REQ-024 When mul_out_vld is high, res_vld SHALL be one-hot at the tag-line output id on the next cycle, with res_a/res_b set to mul_a_out/mul_b_out. Total latency from transfer to res_vld is MUL_LAT+2 cycles.
REQ-025 When mul_out_vld and the tag-line output valid disagree, err SHALL set and hold until reset; no res_vld is issued for that cycle.
REQ-026 In-flight counter SHALL increment on a transfer, decrement on a result, and stay unchanged when both occur in the same cycle; range 0..MUL_LAT+1, never wrapping.
REQ-027 Back-to-back transfers on every cycle SHALL be sustained (throughput 1 op/cycle), with no bubble between requesters.
REQ-028 en deasserted mid-stream: grants stop on the same cycle, in-flight results still return, idle rises once the counter reaches 0.
REQ-029 Results SHALL return in issue order; no backpressure exists on res_*.

Reset
REQ-030 While rst_n is low at a clock edge: ptr=0, tag line cleared, counter=0, mul_in_vld=0, mul operands=0, res_vld=0, res_a=res_b=0, err=0, mul_rst=1 on the next cycle.
REQ-031 req_rdy SHALL be 0 while rst_n is low.
REQ-032 Reset mid-operation SHALL discard all in-flight operations; late mul_out_vld pulses are masked (no res_vld, no err) for MUL_LAT+1 cycles after reset release.

Structure
REQ-033 A shared package complex_mul_pkg SHALL hold the default DATA_LEN, the default MUL_LAT and the tag struct {valid, id}.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, ptr; output: one-hot grant).

Verification
REQ-035 Single request: requester 2 sends (3+4j)*(1-2j) -> res_vld=4'b0100 at MUL_LAT+2 cycles, res_a=11, res_b=-2.
REQ-036 All four requesters hold req_vld high for 8 cycles from ptr=0 -> grants in order 0,1,2,3,0,1,2,3, with res_vld following in the same order and one result per cycle.
REQ-037 Extremes with DATA_LEN=8: (-128-128j)*(-128-128j) -> res_a=0, res_b=32768 truncated to 16 bits as 0x8000; err stays 0.
REQ-038 en dropped after 3 transfers -> req_rdy=0 immediately, 3 results return, idle=1 after the last one.
REQ-039 rst_n pulsed low with 4 operations in flight -> no res_vld afterwards, err=0, idle=1, ptr=0.
REQ-040 Inject a spurious mul_out_vld with an empty tag line -> err=1 and held high; no res_vld.
